// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for multicycle_adder.
// slave is the adder side; master is the side that issues operands and drains results.
interface multicycle_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data_a;
    logic [WIDTH-1:0] i_data_b;
    logic             i_carry;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_carry;
    logic             o_overflow;

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_carry, i_sub, i_ready,
        output o_ready, o_valid, o_data, o_carry, o_overflow
    );

    modport master (
        output i_valid, i_data_a, i_data_b, i_carry, i_sub, i_ready,
        input  o_ready, o_valid, o_data, o_carry, o_overflow
    );
endinterface

// File: rtl/multicycle_adder.sv
// Sequential add/sub unit: CHUNK bits per cycle through a ripple chain,
// inter-chunk carry held in a register, valid/ready on operands and result.
module multicycle_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    multicycle_adder_if.slave    bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SH_W   = $clog2(WIDTH) + 1;
    localparam int unsigned CW1    = CHUNK + 1;
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic [SH_W-1:0]  sh;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] psum_next;
    logic             msb_cin;
    logic             last;

    // One chunk of the ripple chain, selected by the chunk counter
    always_comb begin
        sh        = SH_W'(cnt) * SH_W'(CHUNK);
        a_chunk   = CHUNK'(a_reg >> sh);
        b_chunk   = CHUNK'(b_reg >> sh);
        chunk_res = CW1'(a_chunk) + CW1'(b_chunk) + CW1'(carry);
        psum_next = (psum & ~(CHUNK_MASK << sh)) | (WIDTH'(chunk_res[CHUNK-1:0]) << sh);
        // Carry into the chunk's top bit recovered from its sum bit
        msb_cin   = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
        last      = (cnt == CNT_W'(NCHUNK - 1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            a_reg          <= '0;
            b_reg          <= '0;
            psum           <= '0;
            cnt            <= '0;
            carry          <= 1'b0;
            bus.o_ready    <= 1'b1;
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_carry    <= 1'b0;
            bus.o_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        a_reg       <= bus.i_data_a;
                        b_reg       <= bus.i_sub ? ~bus.i_data_b : bus.i_data_b;
                        carry       <= bus.i_sub | bus.i_carry;
                        cnt         <= '0;
                        bus.o_ready <= 1'b0;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    psum  <= psum_next;
                    carry <= chunk_res[CHUNK];
                    if (last) begin
                        cnt            <= '0;
                        bus.o_data     <= psum_next;
                        bus.o_carry    <= chunk_res[CHUNK];
                        bus.o_overflow <= msb_cin ^ chunk_res[CHUNK];
                        bus.o_valid    <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Ready returns only after the handoff edge, so no accept overlaps it
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        bus.o_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.o_valid <= 1'b0;
                    bus.o_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_adder.sv
// Directed and randomised checks of multicycle_adder across several WIDTH/CHUNK shapes.
module tb_multicycle_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_adder_if #(.WIDTH(32)) if_m   ();
    multicycle_adder_if #(.WIDTH(32)) if_c32 ();
    multicycle_adder_if #(.WIDTH(32)) if_c1  ();
    multicycle_adder_if #(.WIDTH(8))  if_w8  ();

    multicycle_adder #(.WIDTH(32), .CHUNK(8))  dut_m   (.i_clk(clk), .i_rst_n(rst_n), .bus(if_m));
    multicycle_adder #(.WIDTH(32), .CHUNK(32)) dut_c32 (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c32));
    multicycle_adder #(.WIDTH(32), .CHUNK(1))  dut_c1  (.i_clk(clk), .i_rst_n(rst_n), .bus(if_c1));
    multicycle_adder #(.WIDTH(8),  .CHUNK(4))  dut_w8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if_w8));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] d;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Independent reference: full-width sum, overflow from operand/result signs
    function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                  input bit sub, input bit cin, output longint unsigned d,
                                  output bit c, output bit v);
        longint unsigned mask = (64'd1 << w) - 64'd1;
        longint unsigned be   = sub ? (~b & mask) : (b & mask);
        longint unsigned full = (a & mask) + be + (sub ? 64'd1 : 64'(cin));
        d = full & mask;
        c = full[w];
        v = (a[w-1] == be[w-1]) && (d[w-1] != a[w-1]);
    endfunction

    task automatic run_m(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                         output logic [31:0] d, output logic c, output logic v, output int lat);
        @(negedge clk);
        if_m.i_data_a = a; if_m.i_data_b = b; if_m.i_sub = sub; if_m.i_carry = cin;
        if_m.i_valid = 1'b1;
        @(posedge clk); #1;
        if_m.i_valid = 1'b0;
        chk("m_ready_busy", 64'(if_m.o_ready), 64'd0);
        lat = 0;
        while (!if_m.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        d = if_m.o_data; c = if_m.o_carry; v = if_m.o_overflow;
        if_m.i_ready = 1'b1;
        @(posedge clk); #1;
        if_m.i_ready = 1'b0;
    endtask

    task automatic run_c32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                           output logic [31:0] d, output logic c, output logic v, output int lat);
        @(negedge clk);
        if_c32.i_data_a = a; if_c32.i_data_b = b; if_c32.i_sub = sub; if_c32.i_carry = cin;
        if_c32.i_valid = 1'b1;
        @(posedge clk); #1;
        if_c32.i_valid = 1'b0;
        lat = 0;
        while (!if_c32.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        d = if_c32.o_data; c = if_c32.o_carry; v = if_c32.o_overflow;
        if_c32.i_ready = 1'b1;
        @(posedge clk); #1;
        if_c32.i_ready = 1'b0;
    endtask

    task automatic run_c1(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin,
                          output logic [31:0] d, output logic c, output logic v, output int lat);
        @(negedge clk);
        if_c1.i_data_a = a; if_c1.i_data_b = b; if_c1.i_sub = sub; if_c1.i_carry = cin;
        if_c1.i_valid = 1'b1;
        @(posedge clk); #1;
        if_c1.i_valid = 1'b0;
        lat = 0;
        while (!if_c1.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        d = if_c1.o_data; c = if_c1.o_carry; v = if_c1.o_overflow;
        if_c1.i_ready = 1'b1;
        @(posedge clk); #1;
        if_c1.i_ready = 1'b0;
    endtask

    task automatic run_w8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic cin,
                          output logic [7:0] d, output logic c, output logic v, output int lat);
        @(negedge clk);
        if_w8.i_data_a = a; if_w8.i_data_b = b; if_w8.i_sub = sub; if_w8.i_carry = cin;
        if_w8.i_valid = 1'b1;
        @(posedge clk); #1;
        if_w8.i_valid = 1'b0;
        lat = 0;
        while (!if_w8.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        d = if_w8.o_data; c = if_w8.o_carry; v = if_w8.o_overflow;
        if_w8.i_ready = 1'b1;
        @(posedge clk); #1;
        if_w8.i_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]     d, a, b;
        logic [7:0]      d8, a8, b8;
        logic            c, v, sub, cin;
        longint unsigned ed;
        bit              ec, ev;
        int              lat;

        vecs[0] = '{a: 32'h0000_00FF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, d: 32'h0000_0100, c: 1'b0, v: 1'b0};
        vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000, cin: 1'b1, sub: 1'b0, d: 32'h0000_0000, c: 1'b1, v: 1'b0};
        vecs[2] = '{a: 32'h7FFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, d: 32'h8000_0000, c: 1'b0, v: 1'b1};
        vecs[3] = '{a: 32'h0000_0005, b: 32'h0000_0007, cin: 1'b1, sub: 1'b1, d: 32'hFFFF_FFFE, c: 1'b0, v: 1'b0};
        vecs[4] = '{a: 32'h8000_0000, b: 32'h0000_0001, cin: 1'b1, sub: 1'b1, d: 32'h7FFF_FFFF, c: 1'b1, v: 1'b1};
        vecs[5] = '{a: 32'h1234_5678, b: 32'h8765_4321, cin: 1'b0, sub: 1'b0, d: 32'h9999_9999, c: 1'b0, v: 1'b0};
        vecs[6] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, sub: 1'b0, d: 32'h0000_0000, c: 1'b1, v: 1'b1};
        vecs[7] = '{a: 32'h0000_0007, b: 32'h0000_0007, cin: 1'b0, sub: 1'b1, d: 32'h0000_0000, c: 1'b1, v: 1'b0};
        vecs[8] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b1, sub: 1'b0, d: 32'hFFFF_FFFF, c: 1'b1, v: 1'b0};
        vecs[9] = '{a: 32'h0000_0000, b: 32'h8000_0000, cin: 1'b0, sub: 1'b1, d: 32'h8000_0000, c: 1'b0, v: 1'b1};

        rst_n = 1'b0;
        if_m.i_valid = 0;   if_m.i_ready = 0;   if_m.i_data_a = 0;   if_m.i_data_b = 0;   if_m.i_carry = 0;   if_m.i_sub = 0;
        if_c32.i_valid = 0; if_c32.i_ready = 0; if_c32.i_data_a = 0; if_c32.i_data_b = 0; if_c32.i_carry = 0; if_c32.i_sub = 0;
        if_c1.i_valid = 0;  if_c1.i_ready = 0;  if_c1.i_data_a = 0;  if_c1.i_data_b = 0;  if_c1.i_carry = 0;  if_c1.i_sub = 0;
        if_w8.i_valid = 0;  if_w8.i_ready = 0;  if_w8.i_data_a = 0;  if_w8.i_data_b = 0;  if_w8.i_carry = 0;  if_w8.i_sub = 0;
        #13;
        chk("rst_valid", 64'(if_m.o_valid), 64'd0);
        chk("rst_ready", 64'(if_m.o_ready), 64'd1);
        chk("rst_data",  64'(if_m.o_data), 64'd0);
        chk("rst_carry", 64'(if_m.o_carry), 64'd0);
        chk("rst_ovf",   64'(if_m.o_overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_m(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, d, c, v, lat);
            chk($sformatf("vec%0d_data", i),  64'(d), 64'(vecs[i].d));
            chk($sformatf("vec%0d_carry", i), 64'(c), 64'(vecs[i].c));
            chk($sformatf("vec%0d_ovf", i),   64'(v), 64'(vecs[i].v));
            chk($sformatf("vec%0d_lat", i),   64'(lat), 64'd4);
        end

        // Backpressure: result held while new operands are offered
        @(negedge clk);
        if_m.i_data_a = 32'd1; if_m.i_data_b = 32'd2; if_m.i_sub = 1'b0; if_m.i_carry = 1'b0;
        if_m.i_valid = 1'b1;
        @(posedge clk); #1;
        if_m.i_valid = 1'b0;
        lat = 0;
        while (!if_m.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("bp_lat", 64'(lat), 64'd4);
        if_m.i_data_a = 32'h100; if_m.i_data_b = 32'h200; if_m.i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(if_m.o_valid), 64'd1);
            chk("bp_data",  64'(if_m.o_data), 64'd3);
            chk("bp_ready", 64'(if_m.o_ready), 64'd0);
        end
        if_m.i_ready = 1'b1;
        @(posedge clk); #1;
        if_m.i_ready = 1'b0;
        chk("rel_valid", 64'(if_m.o_valid), 64'd0);
        chk("rel_ready", 64'(if_m.o_ready), 64'd1);
        chk("rel_data",  64'(if_m.o_data), 64'd3);
        @(posedge clk); #1;
        if_m.i_valid = 1'b0;
        chk("next_acc_ready", 64'(if_m.o_ready), 64'd0);
        lat = 0;
        while (!if_m.o_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        chk("next_lat",  64'(lat), 64'd4);
        chk("next_data", 64'(if_m.o_data), 64'h300);
        if_m.i_ready = 1'b1;
        @(posedge clk); #1;
        if_m.i_ready = 1'b0;

        // Leave a distinctive result behind, then abort an operation mid-CALC
        run_m(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, d, c, v, lat);
        chk("pre_rst_data", 64'(d), 64'h8000_0000);
        @(negedge clk);
        if_m.i_data_a = 32'h1111_1111; if_m.i_data_b = 32'h2222_2222; if_m.i_valid = 1'b1;
        @(posedge clk); #1;
        if_m.i_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(if_m.o_valid), 64'd0);
        chk("mid_rst_data",  64'(if_m.o_data), 64'd0);
        chk("mid_rst_ready", 64'(if_m.o_ready), 64'd1);
        chk("mid_rst_ovf",   64'(if_m.o_overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 64'(if_m.o_valid), 64'd0);
        run_m(32'd3, 32'd4, 1'b0, 1'b0, d, c, v, lat);
        chk("post_rst_data", 64'(d), 64'd7);
        chk("post_rst_lat",  64'(lat), 64'd4);

        for (int i = 0; i < 200; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            model(32, 64'(a), 64'(b), sub, cin, ed, ec, ev);
            run_c32(a, b, sub, cin, d, c, v, lat);
            chk("c32_data", 64'(d), ed);
            chk("c32_carry", 64'(c), 64'(ec));
            chk("c32_ovf", 64'(v), 64'(ev));
            chk("c32_lat", 64'(lat), 64'd1);
        end

        for (int i = 0; i < 200; i++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            model(32, 64'(a), 64'(b), sub, cin, ed, ec, ev);
            run_c1(a, b, sub, cin, d, c, v, lat);
            chk("c1_data", 64'(d), ed);
            chk("c1_carry", 64'(c), 64'(ec));
            chk("c1_ovf", 64'(v), 64'(ev));
            chk("c1_lat", 64'(lat), 64'd32);
        end

        for (int i = 0; i < 200; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
            model(8, 64'(a8), 64'(b8), sub, cin, ed, ec, ev);
            run_w8(a8, b8, sub, cin, d8, c, v, lat);
            chk("w8_data", 64'(d8), ed);
            chk("w8_carry", 64'(c), 64'(ec));
            chk("w8_ovf", 64'(v), 64'(ev));
            chk("w8_lat", 64'(lat), 64'd2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_adder.md
Name: multicycle_adder

Overview:
- Parametrised, sequential successor to the single-bit half/full adder cells.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through an internal ripple chain, carrying between chunks in a register.
- Uses a valid/ready handshake on both input and result.
- Sits beside the ALU as an area-reduced add/sub unit and as a reusable arithmetic primitive for multi-cycle datapaths.

Parameters:
- WIDTH, 32, operand and result width in bits; must be ≥1.
- CHUNK, 8, bits added per compute cycle; must satisfy 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0, otherwise elaboration fails.
- NCHUNK (localparam) = WIDTH/CHUNK, the number of compute cycles.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  operands valid.
- o_ready  out  1  block can accept operands; equals (state==IDLE).
- i_data_a  in  WIDTH  operand A.
- i_data_b  in  WIDTH  operand B.
- i_carry  in  1  carry-in for add; ignored when i_sub=1.
- i_sub  in  1  0: A+B+i_carry; 1: A-B, computed as A+~B+1.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_data  out  WIDTH  sum/difference.
- o_carry  out  1  carry out of the MSB; for subtract, 1 = no borrow.
- o_overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - o_valid=0, o_data=0, o_carry=0, o_overflow=0.
  - o_ready=1.
  - Internal operand, partial-sum, chunk-counter and carry registers = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid=1 at a rising edge (accept):
    - latch A.
    - latch B_eff = i_sub ? ~B : B.
    - carry register ← i_sub ? 1 : i_carry.
    - counter ← 0.
    - go to CALC.
  - i_valid=0 → stay in IDLE.
- CALC:
  - o_ready=0; i_valid is ignored.
  - Each cycle, chunk k = counter adds A[k*CHUNK +: CHUNK] + B_eff[same slice] + carry:
    - the CHUNK-bit result is written to the partial-sum slice.
    - carry register ← chunk carry-out.
    - counter increments.
  - On the last chunk (counter == NCHUNK-1):
    - o_data ← the complete partial sum, including this cycle's slice.
    - o_carry ← final carry-out.
    - o_overflow ← carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
    - o_valid ← 1; state → DONE.
- Latency: o_valid rises NCHUNK rising edges after the accept edge (32/8 → 4; CHUNK=WIDTH → 1; CHUNK=1 → WIDTH).
- DONE:
  - o_ready=0; o_valid=1.
  - o_data, o_carry and o_overflow are held stable for as long as i_ready=0.
  - On i_ready=1 at an edge: o_valid ← 0, state → IDLE.
  - A new operand cannot be accepted on that same edge; the earliest next accept is the following edge.
  - Minimum throughput: one operation per NCHUNK+2 cycles.
- Outputs outside DONE: o_data/o_carry/o_overflow keep the last completed result; they change only on entry to DONE.
- Reset mid-CALC or mid-DONE: the operation is aborted, all outputs immediately take their reset values, and no result is produced.
- Operands are captured at accept; changes on the input buses after accept have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; o_overflow interprets the operands as two's complement.

Test Plan:
- WIDTH=32, CHUNK=8, add A=0x000000FF, B=0x00000001, i_carry=0 → o_data=0x00000100, o_carry=0, o_overflow=0; o_valid high exactly 4 edges after accept; o_ready=0 during CALC/DONE.
- Full ripple across all chunks: A=0xFFFFFFFF, B=0x00000000, i_carry=1 → o_data=0x00000000, o_carry=1, o_overflow=0. Signed overflow: A=0x7FFFFFFF, B=0x00000001 → o_data=0x80000000, o_carry=0, o_overflow=1.
- Subtract (i_sub=1, i_carry=1 ignored):
  - A=5, B=7 → o_data=0xFFFFFFFE, o_carry=0, o_overflow=0.
  - A=0x80000000, B=1 → o_data=0x7FFFFFFF, o_carry=1, o_overflow=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while driving i_valid=1 with new operands → o_valid and outputs stable, o_ready=0, new operands not taken. Raise i_ready → o_valid=0 and o_ready=1 after that edge; a new accept is possible on the next edge.
- Reset asserted during chunk 2 of CALC → o_valid=0, o_data=0, o_ready=1 asynchronously. After release, A=3, B=4 gives o_data=7 with normal latency.
- Parameter sweep, 200 random add/sub operations each against a reference model: CHUNK=32 (latency 1), CHUNK=1 (latency 32), WIDTH=8/CHUNK=4 (latency 2).
